// File: rtl/cam_spi_target.sv
// cam_spi_target: mode-0 SPI target decoding 24-bit frames into a 16-bit register file.
// Optional miso readback path built only when CAM_SPI_TARGET_READBACK_EN is defined.
module cam_spi_target #(
    parameter int REG_COUNT   = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic        c,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [15:0] wr_data,
    input  logic [6:0]  host_raddr,
    output logic [15:0] host_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d, armed_q, armed_d, busy_q, busy_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [22:0]            rx_q, rx_d;
    logic [6:0]             wr_addr_q, wr_addr_d;
    logic [15:0]            wr_data_q, wr_data_d, host_rdata_q, host_rdata_d;
    logic [15:0]            mem_q [128];
    logic [15:0]            mem_d [128];
    logic                   cs_s, sclk_s, mosi_s, act, rise, fall;
    logic [23:0]            frame;

    function automatic logic in_rng(input logic [6:0] a);
        return {1'b0, a} < 8'(REG_COUNT);
    endfunction

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    // armed only after a real cs_n high, so a frame cut by reset is ignored to its end
    assign act    = ~cs_s & armed_q;
    assign rise   = sclk_s & ~sclk_prev_q;
    assign fall   = ~sclk_s & sclk_prev_q;
    assign frame  = {rx_q, mosi_s};

    always_comb begin
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d  = sclk_s;
        armed_d      = armed_q | cs_s;
        busy_d       = act;
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        mem_d        = mem_q;
        host_rdata_d = in_rng(host_raddr) ? mem_q[host_raddr] : 16'h0000;
        if (!act) begin
            state_d = IDLE;
            cnt_d   = '0;
            rx_d    = '0;
        end else if (state_q == IDLE) begin
            state_d = HDR;
        end else if (rise && state_q != DONE) begin
            rx_d  = frame[22:0];
            cnt_d = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd7) ? DATA : (cnt_q == 5'd23) ? DONE : state_q;
            if (cnt_q == 5'd23 && frame[23] && in_rng(frame[22:16])) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = frame[22:16];
                wr_data_d  = frame[15:0];
                mem_d[frame[22:16]] = frame[15:0];
            end
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            cs_sync_q    <= '0;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            rx_q         <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            host_rdata_q <= '0;
            for (int i = 0; i < 128; i++) mem_q[i] <= '0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= host_rdata_d;
            mem_q        <= mem_d;
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;
    assign busy       = busy_q;

`ifdef CAM_SPI_TARGET_READBACK_EN
    logic [15:0] tx_q, tx_d;
    logic        miso_q, miso_d, oe_q, oe_d;

    always_comb begin
        tx_d   = tx_q;
        miso_d = miso_q;
        oe_d   = act;
        if (!act || state_q == IDLE || state_q == DONE) begin
            tx_d   = '0;
            miso_d = 1'b0;
        end else if (state_q == HDR) begin
            miso_d = 1'b0;
            if (rise && cnt_q == 5'd7 && !frame[7])
                tx_d = in_rng(frame[6:0]) ? mem_q[frame[6:0]] : 16'h0000;
        end else if (fall) begin
            miso_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            miso_q <= miso_d;
            oe_q   <= oe_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
`else
    assign spi_miso    = 1'b0;
    assign spi_miso_oe = 1'b0;
`endif
endmodule

// File: tb/tb_cam_spi_target.sv
// tb_cam_spi_target: directed table plus random frames against a register-file model, for REG_COUNT 128 and 16.
module tb_cam_spi_target;
`ifdef CAM_SPI_TARGET_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic c = 1'b0, rst = 1'b1, spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
    logic [6:0] host_raddr = '0;
    logic miso0, oe0, wv0, busy0, miso1, oe1, wv1, busy1;
    logic [6:0] wa0, wa1;
    logic [15:0] wd0, wd1, host0, host1;

    always #5 c = ~c;

    cam_spi_target u0 (
        .c(c), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(miso0), .spi_miso_oe(oe0), .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0),
        .host_raddr(host_raddr), .host_rdata(host0), .busy(busy0)
    );
    cam_spi_target #(.REG_COUNT(16)) u1 (
        .c(c), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(miso1), .spi_miso_oe(oe1), .wr_valid(wv1), .wr_addr(wa1), .wr_data(wd1),
        .host_raddr(host_raddr), .host_rdata(host1), .busy(busy1)
    );

    int n_chk = 0, n_fail = 0;
    int wc0 = 0, wc1 = 0, miso_bad = 0;
    logic [6:0] la0;
    logic [15:0] ld0;
    logic [15:0] m0 [128];
    logic [15:0] m1 [128];
    logic [15:0] cap0, cap1;
    logic hdr_hi, oe_lo, oe_hi, busy_lo;
    bit watch_on = 0, watch_done = 0, wv_prev = 0;
    logic [15:0] watch_old, watch_new;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge c) begin
        if (watch_on && wv_prev && !watch_done) begin
            chk("host_after_write", 32'(host0), 32'(watch_new));
            watch_done = 1;
        end else if (watch_on && wv0 && !watch_done) begin
            chk("host_during_write", 32'(host0), 32'(watch_old));
        end
        wv_prev = wv0;
        if (wv0) begin wc0++; la0 = wa0; ld0 = wd0; end
        if (wv1) wc1++;
        if (!RB && (miso0 | oe0 | miso1 | oe1)) miso_bad++;
    end

    // drives one frame of nb bits; rst_after>0 pulses rst during the high phase after that rise
    task automatic frame(input logic [23:0] f, input int nb, input int rst_after);
        cap0 = '0; cap1 = '0; hdr_hi = 0; oe_lo = 0; oe_hi = 0; busy_lo = 0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge c);
        for (int i = 0; i < nb; i++) begin
            spi_mosi = (i < 24) ? f[23-i] : 1'b1;
            repeat (8) @(negedge c);
            if (rst_after == 0 || i < rst_after) begin
                if (i < 8) hdr_hi |= miso0 | miso1;
                if (i >= 8 && i < 24) begin cap0 = {cap0[14:0], miso0}; cap1 = {cap1[14:0], miso1}; end
                oe_lo |= ~oe0 | ~oe1;
                oe_hi |= oe0 | oe1;
                busy_lo |= ~busy0 | ~busy1;
            end
            spi_sclk = 1'b1;
            if (i + 1 == rst_after) begin
                repeat (3) @(negedge c);
                rst = 1'b1;
                @(negedge c);
                rst = 1'b0;
                chk("rst_wr_valid", 32'(wv0), 0);
                chk("rst_wr_addr", 32'(wa0), 0);
                chk("rst_wr_data", 32'(wd0), 0);
                chk("rst_host_rdata", 32'(host0), 0);
                chk("rst_busy", 32'(busy0), 0);
                chk("rst_miso_oe", 32'({miso0, oe0}), 0);
                repeat (4) @(negedge c);
            end else begin
                repeat (8) @(negedge c);
            end
            spi_sclk = 1'b0;
        end
        repeat (6) @(negedge c);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge c);
        chk("miso_in_header", 32'(hdr_hi), 0);
        chk("miso_oe_level", 32'(RB ? oe_lo : oe_hi), 0);
        chk("busy_in_frame", 32'(busy_lo), 0);
    endtask

    task automatic model(input logic [23:0] f, input int nb);
        if (f[23] && nb >= 24) begin
            m0[f[22:16]] = f[15:0];
            if (f[22:16] < 7'd16) m1[f[22:16]] = f[15:0];
        end
    endtask

    task automatic host_chk(input logic [6:0] a);
        host_raddr = a;
        repeat (2) @(negedge c);
        chk("host0_model", 32'(host0), 32'(m0[a]));
        chk("host1_model", 32'(host1), 32'(a < 7'd16 ? m1[a] : 16'h0000));
    endtask

    typedef struct {
        logic [23:0] f;
        int nb, dw0, dw1;
        logic [15:0] rd0, rd1, hv0, hv1;
    } vec_t;
    vec_t tv [9];

    initial begin
        int w0, w1, nb, e0, e1;
        logic [6:0] a;
        logic [15:0] d;
        logic w;
        logic [23:0] f;
        tv[0] = '{24'h92_3456, 24, 1, 0, 16'h0000, 16'h0000, 16'h3456, 16'h0000};
        tv[1] = '{24'h12_0000, 24, 0, 0, 16'h3456, 16'h0000, 16'h3456, 16'h0000};
        tv[2] = '{24'h85_AAAA, 10, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tv[3] = '{24'h05_0000, 24, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tv[4] = '{24'hA0_BEEF, 24, 1, 0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
        tv[5] = '{24'h20_0000, 24, 0, 0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
        tv[6] = '{24'h83_1234, 24, 1, 1, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
        tv[7] = '{24'h03_FFFF, 24, 0, 0, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        tv[8] = '{24'h83_5555, 26, 1, 1, 16'h0000, 16'h0000, 16'h5555, 16'h5555};
        for (int i = 0; i < 128; i++) begin m0[i] = '0; m1[i] = '0; end
        repeat (3) @(negedge c);
        rst = 1'b0;
        chk("reset_wr_valid", 32'({wv0, wv1}), 0);
        chk("reset_wr_addr_data", 32'({wa0, wd0}), 0);
        chk("reset_host_rdata", 32'({host0, host1}), 0);
        chk("reset_busy_miso_oe", 32'({busy0, miso0, oe0, busy1, miso1, oe1}), 0);
        repeat (10) @(negedge c);

        for (int i = 0; i < 9; i++) begin
            w0 = wc0; w1 = wc1;
            frame(tv[i].f, tv[i].nb, 0);
            chk("tbl_wr_count0", 32'(wc0 - w0), 32'(tv[i].dw0));
            chk("tbl_wr_count1", 32'(wc1 - w1), 32'(tv[i].dw1));
            if (tv[i].dw0 == 1) chk("tbl_wr_addr_data", 32'({la0, ld0}), 32'({tv[i].f[22:16], tv[i].f[15:0]}));
            chk("tbl_read0", 32'(cap0), 32'(RB ? tv[i].rd0 : 16'h0000));
            chk("tbl_read1", 32'(cap1), 32'(RB ? tv[i].rd1 : 16'h0000));
            model(tv[i].f, tv[i].nb);
            host_raddr = tv[i].f[22:16];
            repeat (2) @(negedge c);
            chk("tbl_host0", 32'(host0), 32'(tv[i].hv0));
            chk("tbl_host1", 32'(host1), 32'(tv[i].hv1));
        end

        // reset after the 12th rise: the remainder of that frame must not write
        w0 = wc0; w1 = wc1;
        frame(24'h92_7777, 24, 12);
        for (int i = 0; i < 128; i++) begin m0[i] = '0; m1[i] = '0; end
        chk("rst_frame_no_write", 32'((wc0 - w0) + (wc1 - w1)), 0);
        host_chk(7'h03);
        host_chk(7'h12);

        watch_old = 16'h0000; watch_new = 16'hABCD; watch_on = 1;
        w0 = wc0;
        frame(24'h92_ABCD, 24, 0);
        watch_on = 0;
        chk("post_rst_write", 32'(wc0 - w0), 1);
        chk("host_follow_seen", 32'(watch_done), 1);
        model(24'h92_ABCD, 24);

        for (int k = 0; k < 30; k++) begin
            a  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
            w  = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 23)) : (($urandom_range(0, 4) == 0) ? 26 : 24);
            f  = {w, a, d};
            w0 = wc0; w1 = wc1;
            frame(f, nb, 0);
            e0 = (w && nb >= 24) ? 1 : 0;
            e1 = (w && nb >= 24 && a < 7'd16) ? 1 : 0;
            chk("rnd_wr_count0", 32'(wc0 - w0), 32'(e0));
            chk("rnd_wr_count1", 32'(wc1 - w1), 32'(e1));
            if (e0 == 1) chk("rnd_wr_addr_data", 32'({la0, ld0}), 32'({a, d}));
            if (!w && nb >= 24) begin
                chk("rnd_read0", 32'(cap0), 32'(RB ? m0[a] : 16'h0000));
                chk("rnd_read1", 32'(cap1), 32'((RB && a < 7'd16) ? m1[a] : 16'h0000));
            end
            model(f, nb);
            host_chk(($urandom_range(0, 1) == 0) ? a : 7'($urandom_range(0, 31)));
        end

        chk("miso_quiet_without_readback", 32'(miso_bad), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
